// File: rtl/mul_pkg.sv
// Types and constants shared by the shift-add multiplier and its helpers.
package mul_pkg;

   localparam int MUL_DEFAULT_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      FIXUP = 2'd2,
      DONE  = 2'd3
   } mul_state_t;

   // Counter width that can hold 0..width inclusive.
   function automatic int mul_cnt_width(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/mul_sign_abs.sv
// Splits a two's-complement operand into sign bit and unsigned magnitude.
// The most negative input maps to magnitude 2^(WIDTH-1), which fits WIDTH unsigned bits.
module mul_sign_abs #(
   parameter int WIDTH = 32
) (
   input  logic signed [WIDTH-1:0] i_val,
   output logic        [WIDTH-1:0] o_mag,
   output logic                    o_sign
);

   assign o_sign = i_val[WIDTH-1];
   assign o_mag  = o_sign ? WIDTH'(-i_val) : WIDTH'(i_val);

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential signed multiplier: sign-magnitude shift-add, one multiplier bit per CALC cycle.
// Latency WIDTH+3 edges start-to-valid; start ignored while busy; MUL_ADD_REMAINDER_EN adds a signed addend.
module shift_add_multiplier
   import mul_pkg::*;
#(
   parameter int WIDTH = MUL_DEFAULT_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic signed [WIDTH-1:0]   quotient,
   input  logic signed [WIDTH-1:0]   divisor,
`ifdef MUL_ADD_REMAINDER_EN
   input  logic signed [WIDTH-1:0]   remainder,
`endif
   output logic signed [2*WIDTH-1:0] product,
   output logic                      busy,
   output logic                      valid
);

   localparam int CW = mul_cnt_width(WIDTH);

   mul_state_t          r_state;
   logic [WIDTH-1:0]    r_mcand;
   logic [WIDTH-1:0]    r_mplier;
   logic [WIDTH-1:0]    r_acc;
   logic [CW-1:0]       r_cnt;
   logic                r_sign;
   logic [2*WIDTH-1:0]  r_product;
   logic                r_valid;
`ifdef MUL_ADD_REMAINDER_EN
   logic [WIDTH-1:0]    r_rem;
`endif

   logic [WIDTH-1:0]    w_q_mag;
   logic [WIDTH-1:0]    w_d_mag;
   logic                w_q_sign;
   logic                w_d_sign;
   logic [WIDTH:0]      w_sum;
   logic                w_last;
   logic [2*WIDTH-1:0]  w_mag;
   logic [2*WIDTH-1:0]  w_signed;
   logic [2*WIDTH-1:0]  w_fixed;

   mul_sign_abs #(.WIDTH(WIDTH)) u_abs_q (
      .i_val  (quotient),
      .o_mag  (w_q_mag),
      .o_sign (w_q_sign)
   );

   mul_sign_abs #(.WIDTH(WIDTH)) u_abs_d (
      .i_val  (divisor),
      .o_mag  (w_d_mag),
      .o_sign (w_d_sign)
   );

   // One extra bit holds the carry out of the partial-product add before the shift.
   assign w_sum  = r_mplier[0] ? ({1'b0, r_acc} + {1'b0, r_mcand}) : {1'b0, r_acc};
   assign w_last = (r_cnt == CW'(WIDTH - 1));

   assign w_mag    = {r_acc, r_mplier};
   assign w_signed = r_sign ? -w_mag : w_mag;
`ifdef MUL_ADD_REMAINDER_EN
   assign w_fixed  = w_signed + {{WIDTH{r_rem[WIDTH-1]}}, r_rem};
`else
   assign w_fixed  = w_signed;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_sign    <= 1'b0;
         r_product <= '0;
         r_valid   <= 1'b0;
`ifdef MUL_ADD_REMAINDER_EN
         r_rem     <= '0;
`endif
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_mcand  <= w_q_mag;
                  r_mplier <= w_d_mag;
                  r_sign   <= w_q_sign ^ w_d_sign;
                  r_acc    <= '0;
                  r_cnt    <= '0;
`ifdef MUL_ADD_REMAINDER_EN
                  r_rem    <= remainder;
`endif
                  r_state  <= CALC;
               end
            end
            CALC: begin
               // Shift {carry, acc, mplier} right by one; low product bits fill mplier from the top.
               r_acc    <= w_sum[WIDTH:1];
               r_mplier <= {w_sum[0], r_mplier[WIDTH-1:1]};
               r_cnt    <= r_cnt + CW'(1);
               if (w_last) begin
                  r_state <= FIXUP;
               end
            end
            FIXUP: begin
               {r_acc, r_mplier} <= w_fixed;
               r_state           <= DONE;
            end
            DONE: begin
               r_product <= {r_acc, r_mplier};
               r_valid   <= 1'b1;
               r_state   <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign product = r_product;
   assign valid   = r_valid;
   assign busy    = (r_state != IDLE);

endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits; the legal range is 4..64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request a multiply; sampled only in IDLE.
REQ-005 The block SHALL have ports quotient and divisor, input, WIDTH bits each, signed: the multiplicand and multiplier.
REQ-006 The block SHALL have port remainder, input, WIDTH bits, signed, present only with MUL_ADD_REMAINDER_EN: the addend.
REQ-007 The block SHALL have port product, output, 2*WIDTH bits, signed: the result.
REQ-008 The block SHALL have ports busy and valid, output, 1 bit each: busy marks an operation in progress; valid is a one-cycle result strobe.

Function
REQ-009 The block SHALL implement the states IDLE, CALC, FIXUP and DONE.
REQ-010 In IDLE with start=1, the block SHALL capture both operands, convert them to magnitudes, record the sign as quotient[MSB]^divisor[MSB], clear the accumulator and bit counter, and go to CALC.
REQ-011 In IDLE with start=0, the block SHALL remain in IDLE.
REQ-012 In CALC, each cycle the block SHALL test the multiplier magnitude LSB, add the multiplicand magnitude into the upper accumulator half when that bit is 1, shift the {accumulator, multiplier} pair right by one, and increment the counter.
REQ-013 The block SHALL leave CALC after exactly WIDTH cycles.
REQ-014 In FIXUP, the block SHALL negate the 2*WIDTH-bit magnitude when the recorded sign is 1.
REQ-015 When MUL_ADD_REMAINDER_EN is defined, FIXUP SHALL also add the sign-extended remainder, wrapping modulo 2^(2*WIDTH).
REQ-016 In DONE, the block SHALL register the result to product, drive valid=1 for exactly one cycle, and return to IDLE.
REQ-017 Latency SHALL be fixed at WIDTH+3 cycles from the start-sampling edge to the valid-high edge, independent of operand values.
REQ-018 busy SHALL be 1 in CALC, FIXUP and DONE, and 0 in IDLE.
REQ-019 start SHALL be ignored while busy=1; it is neither queued nor able to corrupt the operation.
REQ-020 start asserted in the same cycle that DONE returns to IDLE SHALL be ignored; a new start SHALL be accepted on the following cycle at the earliest.
REQ-021 product SHALL hold its value until the next DONE and SHALL not change in any other state.
REQ-022 The operand value -2^(WIDTH-1) SHALL be handled as magnitude 2^(WIDTH-1) with a WIDTH-bit unsigned representation, without overflow.
REQ-023 A zero operand SHALL yield product 0 with normal latency.

Reset
REQ-024 rst=1 SHALL set the state to IDLE, busy=0, valid=0, product=0, and clear the accumulator, counter and sign.
REQ-025 rst=1 SHALL take precedence over start and over every state, including mid-CALC; an aborted operation SHALL produce no valid pulse.

Configuration
REQ-026 Macro MUL_ADD_REMAINDER_EN SHALL control remainder reconstruction.
REQ-027 When MUL_ADD_REMAINDER_EN is defined, the remainder port SHALL exist, be captured at start, and product SHALL equal quotient*divisor+remainder.
REQ-028 When MUL_ADD_REMAINDER_EN is undefined, the remainder port and its register SHALL be absent and product SHALL equal quotient*divisor.
REQ-029 Latency SHALL be identical with and without MUL_ADD_REMAINDER_EN.

Structure
REQ-030 Shared package mul_pkg SHALL hold the state enum mul_state_t {IDLE, CALC, FIXUP, DONE} and the constant MUL_DEFAULT_WIDTH=32.
REQ-031 Sub-module mul_sign_abs (combinational: signed in, magnitude plus sign-bit out) SHALL be instantiated once per operand.
REQ-032 The block SHALL need no other sub-modules.

Verification
REQ-033 quotient=7, divisor=-3 -> product=-21; valid high exactly at cycle WIDTH+3; busy falls together with valid.
REQ-034 quotient=divisor=-2^31 (WIDTH=32) -> product=0x4000_0000_0000_0000; quotient=0, divisor=-5 -> product=0.
REQ-035 With MUL_ADD_REMAINDER_EN: quotient=-4, divisor=3, remainder=-2 -> product=-14; quotient=5, divisor=4, remainder=3 -> product=23.
REQ-036 Second start with different operands pulsed at cycles 1, 10 and in the DONE cycle -> only the first result is produced, exactly one valid pulse, and product unchanged by the later operands.
REQ-037 rst asserted at CALC cycle 5 -> next cycle busy=0, valid=0, product=0; no valid pulse follows; a fresh start then completes correctly.
REQ-038 A bench SHALL run 10,000 random signed operand pairs back-to-back, each start issued the cycle after IDLE is entered, and compare product against a reference model.
